// File: rtl/spi_pkg.sv
// Shared types for spi_cmd_sequencer: FSM state encoding, frame width and frame packing.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} seq_state_e;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Frame is {we, addr, we ? wdata : 0}; caller truncates to frame_w().
    function automatic logic [63:0] frame_pack(input logic we, input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input int addr_w, input int data_w);
        logic [63:0] f;
        f = ({63'd0, we} << (addr_w + data_w)) | ({32'd0, addr} << data_w);
        if (we) f = f | {32'd0, wdata};
        return f;
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Host command/response and spi_master handshake bundle for spi_cmd_sequencer.
interface spi_cmd_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_we;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [DATA_W-1:0]        cmd_wdata;
    logic                     cmd_cs;
    logic                     rsp_valid;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     tx_valid;
    logic [ADDR_W+DATA_W:0]   tx_data;
    logic                     cs_sel;
    logic                     rx_ready;
    logic [DATA_W-1:0]        rx_data;

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_cs, rx_ready, rx_data,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_data, cs_sel
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_cs, rx_ready, rx_data,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_data, cs_sel
    );

endinterface

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from an extra wrap bit on each pointer.
module spi_cmd_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues host RAM commands and feeds them one frame at a time to spi_master.
// Define SPI_SEQ_TIMEOUT_EN to abort an ISSUE that sees no rx_ready within TIMEOUT cycles.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_cmd_sequencer_if.slave   bus
);
    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);

    typedef struct packed {
        logic              we;
        logic              cs;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t head, cmd_in;
    logic full, empty, push, pop;

    seq_state_e         state_q, state_d;
    logic               tx_valid_q, tx_valid_d;
    logic [FRAME_W-1:0] tx_data_q, tx_data_d;
    logic               cs_sel_q, cs_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               timeout_hit;

    assign cmd_in = '{we: bus.cmd_we, cs: bus.cmd_cs, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign push   = bus.cmd_valid & ~full;
    assign pop    = (state_q == IDLE) & ~empty;

    spi_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (state_q == ISSUE) ? cnt_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        cs_sel_d    = cs_sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (!empty) begin
                state_d    = ISSUE;
                tx_valid_d = 1'b1;
                tx_data_d  = FRAME_W'(frame_pack(head.we, 32'(head.addr), 32'(head.wdata),
                                                 ADDR_W, DATA_W));
                cs_sel_d   = head.cs;
            end
            // rx_ready takes priority over a timeout landing in the same cycle.
            ISSUE: if (bus.rx_ready) begin
                state_d     = DONE;
                tx_valid_d  = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = tx_data_q[FRAME_W-1] ? '0 : bus.rx_data;
                rsp_err_d   = 1'b0;
            end else if (timeout_hit) begin
                state_d     = DONE;
                tx_valid_d  = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            cs_sel_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            cs_sel_q    <= cs_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = ~full;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.cs_sel    = cs_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: vector table plus backlog, reset and timeout sequences.
module tb_spi_cmd_sequencer;
    localparam int DATA_W = 8, ADDR_W = 5, DEPTH = 4, TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spi_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic        cs;
        logic [7:0]  rx;
        logic [13:0] exp_tx;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;

    always @(negedge clk) if (bus.rsp_valid === 1'b1) rsp_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = v.we;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_cs    = v.cs;
    endtask

    task automatic push(input vec_t v, input string name);
        drive_cmd(v);
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
        chk({name, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input string name);
        for (int i = 0; i < 20 && !bus.tx_valid; i++) tick();
        chk({name, "_tx_valid"}, 32'(bus.tx_valid), 1);
    endtask

    // Drives rx_ready for one cycle, then checks the DONE and IDLE cycles that follow.
    task automatic finish_rsp(input logic [7:0] rx, input logic [7:0] exp_rd, input string name);
        bus.rx_ready = 1'b1;
        bus.rx_data  = rx;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
        chk({name, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        chk({name, "_rsp_err"},   32'(bus.rsp_err), 0);
        chk({name, "_done_tx_low"}, 32'(bus.tx_valid), 0);
        tick();
        chk({name, "_rsp_pulse"}, 32'(bus.rsp_valid), 0);
        chk({name, "_idle_tx_low"}, 32'(bus.tx_valid), 0);
    endtask

    task automatic serve(input vec_t v, input string name);
        wait_tx(name);
        chk({name, "_tx_data"}, 32'(bus.tx_data), 32'(v.exp_tx));
        chk({name, "_cs_sel"},  32'(bus.cs_sel),  32'(v.cs));
        repeat (2) tick();
        chk({name, "_tx_hold"},   32'(bus.tx_valid), 1);
        chk({name, "_data_hold"}, 32'(bus.tx_data), 32'(v.exp_tx));
        chk({name, "_cs_hold"},   32'(bus.cs_sel),  32'(v.cs));
        finish_rsp(v.rx, v.exp_rd, name);
    endtask

    initial begin
        int base;
        int n;
        vecs[0] = '{1'b1, 5'h04, 8'h89, 1'b1, 8'hEE, 14'h2489, 8'h00};
        vecs[1] = '{1'b0, 5'h09, 8'h00, 1'b0, 8'h5A, 14'h0900, 8'h5A};
        vecs[2] = '{1'b1, 5'h1F, 8'hFF, 1'b0, 8'h11, 14'h3FFF, 8'h00};
        vecs[3] = '{1'b0, 5'h00, 8'hAB, 1'b1, 8'hC3, 14'h0000, 8'hC3};
        vecs[4] = '{1'b1, 5'h10, 8'h00, 1'b0, 8'h42, 14'h3000, 8'h00};
        vecs[5] = '{1'b0, 5'h15, 8'h77, 1'b1, 8'h3C, 14'h1500, 8'h3C};

        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_cs = 1'b0;
        bus.rx_ready  = 1'b0; bus.rx_data = '0;

        #12;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_rsp_err",   32'(bus.rsp_err), 0);
        chk("rst_tx_valid",  32'(bus.tx_valid), 0);
        chk("rst_tx_data",   32'(bus.tx_data), 0);
        chk("rst_cs_sel",    32'(bus.cs_sel), 1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // rx_ready while idle must not produce a response
        bus.rx_ready = 1'b1;
        repeat (3) tick();
        bus.rx_ready = 1'b0;
        tick();
        chk("idle_rx_no_rsp", 32'(rsp_cnt), 0);
        chk("idle_rx_no_tx",  32'(bus.tx_valid), 0);

        // single write, single read
        for (int i = 0; i < 2; i++) begin
            push(vecs[i], $sformatf("v%0d", i));
            serve(vecs[i], $sformatf("v%0d", i));
        end

        // backlog: first command parks in ISSUE while four more fill the FIFO
        base = rsp_cnt;
        push(vecs[2], "bl2");
        wait_tx("bl2");
        push(vecs[3], "bl3");
        push(vecs[4], "bl4");
        push(vecs[5], "bl5");
        push(vecs[0], "bl0");
        chk("bl_full_ready", 32'(bus.cmd_ready), 0);
        drive_cmd(vecs[1]);
        repeat (3) tick();
        chk("bl_full_hold", 32'(bus.cmd_ready), 0);
        chk("bl2_tx_data", 32'(bus.tx_data), 32'(vecs[2].exp_tx));
        chk("bl2_cs_sel",  32'(bus.cs_sel),  32'(vecs[2].cs));
        finish_rsp(vecs[2].rx, vecs[2].exp_rd, "bl2");
        for (int i = 0; i < 10 && !bus.cmd_ready; i++) tick();
        chk("bl_reopen", 32'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
        serve(vecs[3], "bl3");
        serve(vecs[4], "bl4");
        serve(vecs[5], "bl5");
        serve(vecs[0], "bl0");
        serve(vecs[1], "bl1");
        chk("bl_rsp_count", 32'(rsp_cnt - base), 6);

        // reset mid-ISSUE with one more command queued
        push(vecs[0], "rs0");
        wait_tx("rs0");
        push(vecs[1], "rs1");
        base = rsp_cnt;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_tx_valid",  32'(bus.tx_valid), 0);
        chk("mid_rst_tx_data",   32'(bus.tx_data), 0);
        chk("mid_rst_cs_sel",    32'(bus.cs_sel), 1);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (6) begin
            tick();
            if (bus.tx_valid) n++;
        end
        chk("post_rst_no_issue", 32'(n), 0);
        chk("post_rst_no_rsp",   32'(rsp_cnt - base), 0);

        // stalled ISSUE with rx_ready held low
        push(vecs[1], "to1");
        wait_tx("to1");
        base = rsp_cnt;
`ifdef SPI_SEQ_TIMEOUT_EN
        n = 0;
        while (bus.tx_valid && n < 200) begin
            n++;
            tick();
        end
        chk("to_issue_cycles", 32'(n), TIMEOUT);
        chk("to_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("to_rsp_err",   32'(bus.rsp_err), 1);
        chk("to_rsp_rdata", 32'(bus.rsp_rdata), 0);
        tick();
        chk("to_rsp_pulse", 32'(bus.rsp_valid), 0);
        push(vecs[5], "to5");
        serve(vecs[5], "to5");
`else
        repeat (100) tick();
        chk("stall_tx_valid", 32'(bus.tx_valid), 1);
        chk("stall_tx_data",  32'(bus.tx_data), 32'(vecs[1].exp_tx));
        chk("stall_no_rsp",   32'(rsp_cnt - base), 0);
        finish_rsp(vecs[1].rx, vecs[1].exp_rd, "stall");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
